rs232_txd: RTL
==============

RS232_TXD -- requirements
Module: rs232_txd

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame (5..8).
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-004 Clock16x  input  1  single clock, 16x baud rate, all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset, sampled on rising Clock16x.
REQ-006 DataIn  input  DATA_BITS  byte to transmit, sampled when Send and Ready both high.
REQ-007 Send  input  1  transmit request, qualified by Ready.
REQ-008 Ready  output  1  holding register empty; high means DataIn is accepted this cycle if Send is high.
REQ-009 Busy  output  1  frame in progress on Txd.
REQ-010 Done  output  1  one-cycle pulse on the last Clock16x cycle of the final stop bit.
REQ-011 Txd  output  1  serial line, idle high.

Function
REQ-012 The frame SHALL be: start bit (0), DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
REQ-013 Each bit SHALL last exactly 16 Clock16x cycles; frame length = 16*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, i.e. 160 for 8N1.
REQ-014 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP; the PARITY state is skipped when PARITY=0.
REQ-015 A 4-bit tick counter (0..15) SHALL advance the FSM on tick==15; a bit counter SHALL count data bits and stop bits.
REQ-016 Even parity SHALL be the XOR of the data bits; odd parity SHALL be its inverse.
REQ-017 Send while Ready high SHALL load DataIn into a one-entry holding register, and Ready SHALL drop on the next edge.
REQ-018 Send while Ready low SHALL be ignored: no data capture, no state change.
REQ-019 In IDLE with the holding register full, the shifter SHALL load from it on the next edge, Ready SHALL return high on that same edge, and Txd SHALL go 0 on that same edge.
REQ-020 Latency SHALL be 2 cycles from Send accepted in IDLE to Txd=0 (capture edge, then load edge).
REQ-021 When the holding register is full at the end of the final stop bit, the next start bit SHALL begin on the immediately following cycle with no idle gap.
REQ-022 A Send accepted on the same cycle the shifter loads from the holding register SHALL be captured without loss.
REQ-023 Busy SHALL be high from the first start-bit cycle through the last stop-bit cycle, and low otherwise.
REQ-024 Done SHALL pulse even when a back-to-back frame follows.
REQ-025 Txd SHALL be driven from a register (glitch-free); it SHALL be 1 in IDLE.

Reset
REQ-026 While Reset=0 at an edge: Txd=1, Ready=1, Busy=0, Done=0, FSM=IDLE, counters=0, holding register empty.
REQ-027 Reset mid-frame SHALL abort the frame; Txd SHALL be 1 after that edge, and the buffered byte SHALL be discarded.
REQ-028 Send SHALL be ignored on any cycle with Reset=0.

Structure
REQ-029 Package rs232_pkg SHALL hold the FSM state encoding, the parity mode constants (NONE/EVEN/ODD) and OVERSAMPLE=16, shared with the receiver.
REQ-030 One sub-module, rs232_bit_timer (tick counter with terminal-count output and clear), is natural and SHALL be used.

Verification
REQ-031 Send 0x55, 8N1 -> Txd=0 for 16 cycles, then 1,0,1,0,1,0,1,0 (16 cycles each), then 1; Done at cycle 160 after Txd falls; Busy low after.
REQ-032 Send 0xA5, then 0x3C as soon as Ready returns -> two frames in 320 contiguous cycles, no idle between stop and start, 2 Done pulses.
REQ-033 Send 0x11, then 0x22 with Ready high, then 0x33 while Ready low -> only 0x11 and 0x22 transmitted.
REQ-034 Send 0xFF, assert Reset=0 at cycle 50 of the frame -> Txd=1 on the next edge, Ready=1, Busy=0, no Done pulse.
REQ-035 PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; frame 176 cycles.
REQ-036 STOP_BITS=2 with 0x00 -> 32 stop cycles high, frame 176 cycles, Done on cycle 176.

Source files
------------

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared UART constants, FSM state encoding and parity helper
package rs232_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  function automatic logic parity_bit(input logic x, input int mode);
    return (mode == PAR_ODD) ? ~x : (mode == PAR_EVEN) ? x : 1'b0;
  endfunction
endpackage

// File: rtl/rs232_bit_timer.sv
// rs232_bit_timer: oversample tick counter with clear and terminal-count output
//   i_clk   : 16x baud clock
//   i_rst_n : synchronous active-low reset
//   i_clr   : synchronous clear to tick 0
//   o_tick  : current tick within the bit (0..OVERSAMPLE-1)
//   o_tc    : high on the last tick of the bit
module rs232_bit_timer
  import rs232_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  output logic [TICK_W-1:0] o_tick,
  output logic              o_tc
);
  logic [TICK_W-1:0] r_tick;
  always_ff @(posedge i_clk)
    r_tick <= (!i_rst_n || i_clr) ? '0 : r_tick + TICK_W'(1);
  assign o_tick = r_tick;
  assign o_tc = r_tick == TICK_W'(OVERSAMPLE - 1);
endmodule

// File: rtl/rs232_txd.sv
// rs232_txd: UART transmitter with one-entry holding register, 16x oversampled
//   Clock16x : 16x baud clock, all logic on rising edge
//   Reset    : synchronous active-low reset
//   DataIn   : word to send, captured when Send && Ready
//   Send     : transmit request
//   Ready    : holding register empty
//   Busy     : frame in progress on Txd
//   Done     : one-cycle pulse on the last cycle of the final stop bit
//   Txd      : registered serial output, idle high
module rs232_txd
  import rs232_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clock16x,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic                 Send,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Txd
);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  state_t               r_state;
  logic [DATA_BITS-1:0] r_hold;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_cnt;
  logic                 r_full;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_busy;
  logic                 r_done;
  logic [TICK_W-1:0]    w_tick;
  logic                 w_tc;
  logic                 w_accept;
  logic                 w_end;
  logic                 w_load;
  logic                 w_last_stop;
  assign w_accept = Send & ~r_full;
  assign w_last_stop = (r_state == S_STOP) & (r_bit_cnt == LAST_STOP);
  assign w_end = w_last_stop & w_tc;
  // the shifter reloads either from idle or straight out of the final stop bit
  assign w_load = r_full & ((r_state == S_IDLE) | w_end);
  rs232_bit_timer u_timer (
    .i_clk  (Clock16x),
    .i_rst_n(Reset),
    .i_clr  (w_load | (r_state == S_IDLE)),
    .o_tick (w_tick),
    .o_tc   (w_tc)
  );
  always_ff @(posedge Clock16x)
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_full    <= 1'b0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_full <= w_accept | (r_full & ~w_load);
      if (w_accept) r_hold <= DataIn;
      // registered a cycle early so the pulse lands on the last stop tick
      r_done <= w_last_stop & (w_tick == TICK_W'(OVERSAMPLE - 2));
      if (w_load) begin
        r_state   <= S_START;
        r_shift   <= r_hold;
        r_par     <= parity_bit(^r_hold, PARITY);
        r_txd     <= 1'b0;
        r_busy    <= 1'b1;
        r_bit_cnt <= '0;
      end else if (w_tc)
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_txd     <= r_shift[0];
            r_bit_cnt <= '0;
          end
          S_DATA:
            if (r_bit_cnt == LAST_DATA) begin
              r_state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
              r_txd     <= (PARITY != PAR_NONE) ? r_par : 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          S_PARITY: begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end
          S_STOP:
            if (r_bit_cnt == LAST_STOP) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else r_bit_cnt <= r_bit_cnt + 3'd1;
          default: r_state <= S_IDLE;
        endcase
    end
  assign Ready = ~r_full;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Txd   = r_txd;
endmodule
